// File: rtl/audio_pkg.sv
// audio_pkg: shared defaults, slot constants and helpers for the I2S speaker path.
package audio_pkg;
    localparam int DATA_W_DEF      = 16;
    localparam int MCLK_LOG2_DEF   = 2;
    localparam int SCK_LOG2_DEF    = 4;
    localparam int LRCK_LOG2_DEF   = 10;
    localparam int FIRST_DATA_SLOT = 1;
    localparam int FRAME_LEN       = 1 << LRCK_LOG2_DEF;

    typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_e;

    function automatic bit slot_has_data(input int slot, input int data_w);
        return slot >= FIRST_DATA_SLOT && slot < FIRST_DATA_SLOT + data_w;
    endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: free-running frame counter with mclk/sck/lrck taps and update strobes.
module i2s_clk_gen #(
    parameter int MCLK_LOG2 = 2,
    parameter int SCK_LOG2  = 4,
    parameter int LRCK_LOG2 = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [LRCK_LOG2-SCK_LOG2-1:0] slot_pos,
    output logic                          mclk,
    output logic                          sck,
    output logic                          lrck,
    output logic                          sdin_upd,
    output logic                          frame_end
);
    logic [LRCK_LOG2-1:0] cnt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Clock outputs are straight register bits so they cannot glitch.
    assign mclk      = cnt[MCLK_LOG2-1];
    assign sck       = cnt[SCK_LOG2-1];
    assign lrck      = cnt[LRCK_LOG2-1];
    assign slot_pos  = cnt[LRCK_LOG2-1:SCK_LOG2];
    assign sdin_upd  = &cnt[SCK_LOG2-1:0];
    assign frame_end = &cnt;
endmodule

// File: rtl/i2s_speaker_tx.sv
// i2s_speaker_tx: 16-bit stereo PCM to I2S serializer with per-frame sample latch.
// Optional I2S_VOLUME_EN adds a 3-bit arithmetic attenuation input applied at the latch.
import audio_pkg::*;

module i2s_speaker_tx #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MCLK_LOG2 = MCLK_LOG2_DEF,
    parameter int SCK_LOG2  = SCK_LOG2_DEF,
    parameter int LRCK_LOG2 = LRCK_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef I2S_VOLUME_EN
    input  logic [2:0]        vol,
`endif
    input  logic [DATA_W-1:0] audio_left,
    input  logic [DATA_W-1:0] audio_right,
    output logic              sample_req,
    output logic              audio_mclk,
    output logic              audio_sck,
    output logic              audio_lrck,
    output logic              audio_sdin
);
    localparam int SLOT_W = LRCK_LOG2 - SCK_LOG2 - 1;

    logic [SLOT_W:0]     slot_pos, pos_nxt;
    logic [SLOT_W-1:0]   slot;
    logic                sdin_upd, frame_end, data_bit;
    logic [DATA_W-1:0]   hold_l, hold_r, lat_l, lat_r, word, word_sh;
    ch_e                 ch;

    i2s_clk_gen #(
        .MCLK_LOG2(MCLK_LOG2),
        .SCK_LOG2 (SCK_LOG2),
        .LRCK_LOG2(LRCK_LOG2)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_pos (slot_pos),
        .mclk     (audio_mclk),
        .sck      (audio_sck),
        .lrck     (audio_lrck),
        .sdin_upd (sdin_upd),
        .frame_end(frame_end)
    );

`ifdef I2S_VOLUME_EN
    assign lat_l = $signed(audio_left) >>> vol;
    assign lat_r = $signed(audio_right) >>> vol;
`else
    assign lat_l = audio_left;
    assign lat_r = audio_right;
`endif

    // sdin is loaded one clk before sck falls, so it looks at the slot being entered.
    always_comb begin
        pos_nxt  = slot_pos + 1'b1;
        slot     = pos_nxt[SLOT_W-1:0];
        ch       = ch_e'(pos_nxt[SLOT_W]);
        word     = (ch == CH_RIGHT) ? hold_r : hold_l;
        word_sh  = word << (slot - SLOT_W'(FIRST_DATA_SLOT));
        data_bit = slot_has_data(int'(slot), DATA_W) ? word_sh[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hold_l     <= '0;
            hold_r     <= '0;
            audio_sdin <= 1'b0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= frame_end;
            if (frame_end) begin
                hold_l <= lat_l;
                hold_r <= lat_r;
            end
            if (sdin_upd)
                audio_sdin <= data_bit;
        end
    end
endmodule

// File: tb/tb_i2s_speaker_tx.sv
// tb_i2s_speaker_tx: per-cycle arithmetic reference model plus frame-level vector table.
module tb_i2s_speaker_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] audio_left = 16'h0, audio_right = 16'h0;
`ifdef I2S_VOLUME_EN
    logic [2:0]  vol = 3'd0;
`endif
    logic        sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin;

    int          total = 0, bad = 0;
    int          k = 0;
    bit          in_rst = 1'b1;
    logic [15:0] cur_l = 16'h0, cur_r = 16'h0;

    typedef struct {
        int          chg_p;
        logic [15:0] cl, cr, el, er;
    } row_t;
    row_t rows[8];

    always #5 clk = ~clk;

    i2s_speaker_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef I2S_VOLUME_EN
        .vol        (vol),
`endif
        .audio_left (audio_left),
        .audio_right(audio_right),
        .sample_req (sample_req),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .audio_sdin (audio_sdin)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0h expected %0h (k=%0d)", name, got, exp, k);
        end
    endtask

    function automatic logic [15:0] atten(input logic [15:0] x);
`ifdef I2S_VOLUME_EN
        int a;
        a = int'($signed(x));
        return 16'(a >>> vol);
`else
        return x;
`endif
    endfunction

    // One clk: advance the model from the frame position and compare every output.
    task automatic tick();
        logic [15:0] nl, nr, w;
        int p, s;
        nl = atten(audio_left);
        nr = atten(audio_right);
        @(posedge clk);
        #1;
        if (in_rst) begin
            chk("rst_req", sample_req, 0);
            chk("rst_mclk", audio_mclk, 0);
            chk("rst_sck", audio_sck, 0);
            chk("rst_lrck", audio_lrck, 0);
            chk("rst_sdin", audio_sdin, 0);
        end else begin
            k++;
            p = k % 1024;
            if (p == 0) begin
                cur_l = nl;
                cur_r = nr;
            end
            s = (p / 16) % 32;
            w = (p >= 512) ? cur_r : cur_l;
            chk("sample_req", sample_req, int'(p == 0));
            chk("mclk", audio_mclk, (p / 2) % 2);
            chk("sck", audio_sck, (p / 8) % 2);
            chk("lrck", audio_lrck, p / 512);
            chk("sdin", audio_sdin, (s >= 1 && s <= 16) ? int'(w[16 - s]) : 0);
        end
    endtask

    // Captures the frame starting now (k%1024==0), optionally changing inputs at position chg_p.
    task automatic run_frame(input int chg_p, input logic [15:0] cl, input logic [15:0] cr,
                             output logic [15:0] wl, output logic [15:0] wr, output int extra);
        wl = 16'h0;
        wr = 16'h0;
        extra = 0;
        for (int i = 0; i < 1024; i++) begin
            int p, s;
            p = k % 1024;
            s = (p / 16) % 32;
            if (p == chg_p) begin
                audio_left  = cl;
                audio_right = cr;
            end
            if (p % 16 == 8) begin
                if (s >= 1 && s <= 16) begin
                    if (p >= 512) wr[16 - s] = audio_sdin;
                    else          wl[16 - s] = audio_sdin;
                end else
                    extra += int'(audio_sdin);
            end
            tick();
        end
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b1;
        #1;
        chk("async_req", sample_req, 0);
        chk("async_mclk", audio_mclk, 0);
        chk("async_sck", audio_sck, 0);
        chk("async_lrck", audio_lrck, 0);
        chk("async_sdin", audio_sdin, 0);
        in_rst = 1'b1;
        repeat (3) tick();
        rst_n  = 1'b0;
        in_rst = 1'b0;
        k      = 0;
        cur_l  = 16'h0;
        cur_r  = 16'h0;
    endtask

    initial begin
        logic [15:0] wl, wr;
        int extra, n;
        rows[0] = '{-1,  16'hB000, 16'h5FFF, 16'h0000, 16'h0000};
        rows[1] = '{476, 16'h1234, 16'h5FFF, 16'hB000, 16'h5FFF};
        rows[2] = '{100, 16'h8000, 16'h7FFF, 16'h1234, 16'h5FFF};
        rows[3] = '{300, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        rows[4] = '{700, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        rows[5] = '{5,   16'hABCD, 16'h0001, 16'h0000, 16'hFFFF};
        rows[6] = '{1000, 16'h7FFF, 16'h8000, 16'hABCD, 16'h0001};
        rows[7] = '{-1,  16'h0000, 16'h0000, 16'h7FFF, 16'h8000};

        audio_left  = 16'hB000;
        audio_right = 16'h5FFF;
        repeat (2) tick();
        rst_n  = 1'b0;
        in_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_frame(rows[i].chg_p, rows[i].cl, rows[i].cr, wl, wr, extra);
            chk($sformatf("row%0d_left", i), wl, rows[i].el);
            chk($sformatf("row%0d_right", i), wr, rows[i].er);
            chk($sformatf("row%0d_pad", i), extra, 0);
            chk($sformatf("row%0d_req", i), sample_req, 1);
        end

        for (int i = 0; i < 6 * 1024; i++) begin
            if ($urandom_range(199) == 0) begin
                audio_left  = 16'($urandom);
                audio_right = 16'($urandom);
            end
            tick();
        end

        while (k % 1024 != 500) tick();
        async_reset();
        n = 0;
        while (!audio_lrck && n < 2000) begin
            tick();
            n++;
        end
        chk("lrck_rise_after_rst", n, 512);
        while (!sample_req && n < 3000) begin
            tick();
            n++;
        end
        chk("first_req_after_rst", n, 1024);

`ifdef I2S_VOLUME_EN
        vol = 3'd3;
        run_frame(100, 16'hB000, 16'h0000, wl, wr, extra);
        vol = 3'd0;
        run_frame(-1, 16'h0, 16'h0, wl, wr, extra);
        chk("vol3_left", wl, 16'hF600);
        run_frame(-1, 16'h0, 16'h0, wl, wr, extra);
        chk("vol0_left", wl, 16'hB000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
